i2c_master_byte_controller: RTL and testbench

- Single-byte I2C master that sits directly downstream of I2C_BaudRateGenerator and consumes its ClockI2C square wave.
- Gates the generator through BaudEnable (wired to the generator's Enable).
- Produces SCL and open-drain SDA for one transaction: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Handshakes with the user logic through Go/Busy/Done.

---
 rtl/i2c_master_byte_controller.sv | 199 +++++++++++++++++++
 tb/tb_i2c_master_byte_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte_controller.sv
// i2c_master_byte_controller
//   Single-byte I2C master. It runs one transaction per Go: START, address plus
//   R/W, ACK, one data byte, ACK/NACK, then STOP. Bus timing comes from an
//   external baud generator square wave, ClockI2C. This block gates that
//   generator through BaudEnable.
// Ports
//   clock, Reset        system clock; asynchronous active-high reset
//   ClockI2C            baud square wave input
//   BaudEnable          enable to the baud generator
//   Go                  start request. It is only honoured in IDLE.
//   ReadWrite           1 = read, 0 = write. Latched on Go.
//   SlaveAddress        7-bit target address. Latched on Go.
//   DataIn              write byte. Latched on Go.
//   DataOut             read byte. Valid while Done is high.
//   Busy / Done         transaction in flight / one-cycle completion pulse
//   AckError            slave NACK seen. Held until the next accepted Go.
//   SCL                 I2C clock
//   SDAOut / SDADrive   open-drain SDA value and drive enable
//   SDAIn               sampled SDA line
module i2c_master_byte_controller #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  ClockI2C,
    output logic                  BaudEnable,
    input  logic                  Go,
    input  logic                  ReadWrite,
    input  logic [ADDR_WIDTH-1:0] SlaveAddress,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  AckError,
    output logic                  SCL,
    output logic                  SDAOut,
    output logic                  SDADrive,
    input  logic                  SDAIn
);

    localparam int SW = ADDR_WIDTH + 1;
    localparam int NB = (SW > DATA_WIDTH) ? SW : DATA_WIDTH;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic                    clk_prev;
    logic                    rise, fall;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           addr_sr;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic                    rw;

    assign rise = ClockI2C & ~clk_prev;
    assign fall = ~ClockI2C & clk_prev;

    // State register
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    // In STOP, cnt tracks the phase:
    //   0 = waiting for the fall that pulls SDA low
    //   1 = waiting for SCL to return high
    //   2 = SCL held high, waiting for the rise that releases SDA
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Go) state_nxt = S_START;
            S_START: if (rise) state_nxt = S_ADDR;
            S_ADDR:  if (rise && cnt == CW'(SW - 1)) state_nxt = S_ACK1;
            S_ACK1:  if (rise) state_nxt = SDAIn ? S_STOP : S_DATA;
            S_DATA:  if (rise && cnt == CW'(DATA_WIDTH - 1)) state_nxt = S_ACK2;
            S_ACK2:  if (rise) state_nxt = S_STOP;
            S_STOP:  if (rise && cnt == CW'(2)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: shift registers, bit counter and SDA drive
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            clk_prev <= 1'b0;
            cnt      <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            rw       <= 1'b0;
            SDAOut   <= 1'b1;
            SDADrive <= 1'b0;
            AckError <= 1'b0;
            DataOut  <= '0;
        end else begin
            clk_prev <= ClockI2C;
            case (state)
                S_IDLE: if (Go) begin
                    addr_sr  <= {SlaveAddress, ReadWrite};
                    data_sr  <= DataIn;
                    rw       <= ReadWrite;
                    AckError <= 1'b0;
                    cnt      <= '0;
                end
                S_START: if (rise) begin
                    // SDA falls while SCL is forced high: START condition
                    SDADrive <= 1'b1;
                    SDAOut   <= 1'b0;
                    cnt      <= '0;
                end
                S_ADDR: begin
                    if (fall) begin
                        SDAOut  <= addr_sr[SW-1];
                        addr_sr <= {addr_sr[SW-2:0], 1'b0};
                    end else if (rise) begin
                        cnt <= (cnt == CW'(SW - 1)) ? '0 : cnt + 1'b1;
                    end
                end
                S_ACK1: begin
                    if (fall) begin
                        SDADrive <= 1'b0;
                    end else if (rise) begin
                        cnt <= '0;
                        if (SDAIn) AckError <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        // Write drives data. Read keeps the line released for the slave.
                        SDADrive <= ~rw;
                        if (!rw) begin
                            SDAOut  <= data_sr[DATA_WIDTH-1];
                            data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else if (rise) begin
                        cnt <= (cnt == CW'(DATA_WIDTH - 1)) ? '0 : cnt + 1'b1;
                        if (rw) DataOut <= {DataOut[DATA_WIDTH-2:0], SDAIn};
                    end
                end
                S_ACK2: begin
                    if (fall) begin
                        // Read: NACK the single byte. Write: release for the slave's ACK.
                        SDADrive <= rw;
                        SDAOut   <= 1'b1;
                    end else if (rise) begin
                        cnt <= '0;
                        if (!rw && SDAIn) AckError <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (fall && cnt == CW'(0)) begin
                        SDADrive <= 1'b1;
                        SDAOut   <= 1'b0;
                        cnt      <= CW'(1);
                    end else if (rise && cnt == CW'(1)) begin
                        cnt <= CW'(2);
                    end else if (rise && cnt == CW'(2)) begin
                        // SDA rises while SCL is held high: STOP condition
                        SDADrive <= 1'b0;
                        SDAOut   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        SCL        = 1'b1;
        Busy       = 1'b0;
        BaudEnable = 1'b0;
        Done       = 1'b0;
        case (state)
            S_START: begin
                Busy       = 1'b1;
                BaudEnable = 1'b1;
            end
            S_ADDR, S_ACK1, S_DATA, S_ACK2: begin
                SCL        = ClockI2C;
                Busy       = 1'b1;
                BaudEnable = 1'b1;
            end
            S_STOP: begin
                SCL        = (cnt == CW'(2)) ? 1'b1 : ClockI2C;
                Busy       = 1'b1;
                BaudEnable = 1'b1;
            end
            S_DONE: Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_byte_controller.sv
module tb_i2c_master_byte_controller;

    logic       clock = 1'b0;
    logic       Reset;
    logic       ClockI2C = 1'b0;
    logic       BaudEnable;
    logic       Go;
    logic       ReadWrite;
    logic [6:0] SlaveAddress;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       Busy, Done, AckError, SCL, SDAOut, SDADrive, SDAIn;

    i2c_master_byte_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clock(clock), .Reset(Reset), .ClockI2C(ClockI2C), .BaudEnable(BaudEnable),
        .Go(Go), .ReadWrite(ReadWrite), .SlaveAddress(SlaveAddress), .DataIn(DataIn),
        .DataOut(DataOut), .Busy(Busy), .Done(Done), .AckError(AckError),
        .SCL(SCL), .SDAOut(SDAOut), .SDADrive(SDADrive), .SDAIn(SDAIn)
    );

    always #5 clock = ~clock;

    // Open-drain bus: wired-AND of master and slave
    logic sl_drv = 1'b0, sl_val = 1'b1;
    logic sda_line;
    assign sda_line = (SDADrive ? SDAOut : 1'b1) & (sl_drv ? sl_val : 1'b1);
    assign SDAIn    = sda_line;

    // Slave configuration
    logic       sl_ack_a, sl_ack_d, sl_rw;
    logic [7:0] sl_rdata;

    // Bus monitor state
    logic [31:0] cap_bits = '0;
    int          cap_n = 0, nstart = 0, nstop = 0, bcnt = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1;

    // Baud generator, bus monitor and slave, all evaluated on the falling edge
    always @(negedge clock) begin
        if (Reset) begin
            sl_drv = 1'b0;
        end else if (SCL && p_scl && p_sda && !sda_line) begin
            nstart++; cap_n = 0; cap_bits = '0; sl_drv = 1'b0;
        end else if (SCL && p_scl && !p_sda && sda_line) begin
            nstop++;
        end else if (SCL && !p_scl) begin
            cap_bits = {cap_bits[30:0], sda_line};
            cap_n++;
        end else if (!SCL && p_scl) begin
            sl_drv = 1'b0; sl_val = 1'b1;
            if (cap_n == 8 && sl_ack_a) begin
                sl_drv = 1'b1; sl_val = 1'b0;
            end else if (cap_n >= 9 && cap_n <= 16 && sl_ack_a && sl_rw) begin
                sl_drv = 1'b1; sl_val = sl_rdata[16 - cap_n];
            end else if (cap_n == 17 && sl_ack_a && !sl_rw && sl_ack_d) begin
                sl_drv = 1'b1; sl_val = 1'b0;
            end
        end
        p_scl = SCL;
        p_sda = sda_line;
        if (!BaudEnable) begin
            ClockI2C = 1'b0; bcnt = 0;
        end else begin
            bcnt++;
            if (bcnt == 5) begin ClockI2C = ~ClockI2C; bcnt = 0; end
        end
    end

    int npass = 0, nchk = 0;
    logic [7:0] m_dout = '0;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: bit sequence seen at each SCL rise, from START to the final STOP clock
    function automatic void exp_seq(input logic [6:0] a, input logic rw, input logic [7:0] d,
                                    input logic aa, input logic ad, input logic [7:0] rd,
                                    output logic [31:0] b, output int n);
        b = {24'd0, a, rw};
        b = {b[30:0], ~aa};
        n = 9;
        if (aa) begin
            b = {b[23:0], (rw ? rd : d)};
            b = {b[30:0], (rw ? 1'b1 : ~ad)};
            n = 18;
        end
        b = {b[30:0], 1'b0};
        n = n + 1;
    endfunction

    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] d,
                           input logic aa, input logic ad, input logic [7:0] rd,
                           input bit interfere);
        logic [31:0] eb;
        int en, s0, p0, ndone;
        bit got;
        sl_ack_a = aa; sl_ack_d = ad; sl_rw = rw; sl_rdata = rd;
        s0 = nstart; p0 = nstop;
        SlaveAddress = a; ReadWrite = rw; DataIn = d; Go = 1'b1;
        @(posedge clock); #1;
        Go = 1'b0;
        chk("busy_after_go", Busy, 1);
        SlaveAddress = 7'($urandom); ReadWrite = 1'($urandom); DataIn = 8'($urandom);
        ndone = 0; got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clock); #1;
            Go = (interfere && i == 40);
            if (interfere && i == 40) SlaveAddress = ~a;
            if (Done) begin ndone++; got = 1; end
        end
        Go = 1'b0;
        chk("done_seen", got, 1);
        if (aa && rw) m_dout = rd;
        chk("ackerror", AckError, (!aa || (!rw && !ad)) ? 1 : 0);
        chk("dataout", DataOut, m_dout);
        chk("busy_at_done", Busy, 0);
        chk("baud_at_done", BaudEnable, 0);
        @(posedge clock); #1;
        if (Done) ndone++;
        chk("done_count", ndone, 1);
        exp_seq(a, rw, d, aa, ad, rd, eb, en);
        chk("start_cnt", nstart - s0, 1);
        chk("stop_cnt", nstop - p0, 1);
        chk("bit_count", cap_n, en);
        chk("bit_seq", cap_bits, eb);
    endtask

    initial begin
        Reset = 1'b1; Go = 1'b0; ReadWrite = 1'b0; SlaveAddress = '0; DataIn = '0;
        sl_ack_a = 1'b1; sl_ack_d = 1'b1; sl_rw = 1'b0; sl_rdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_scl", SCL, 1);
        chk("rst_sdaout", SDAOut, 1);
        chk("rst_sdadrive", SDADrive, 0);
        chk("rst_baud", BaudEnable, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_ackerr", AckError, 0);
        chk("rst_dataout", DataOut, 0);
        Reset = 1'b0;
        @(posedge clock); #1;

        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);   // write, both ACKed
        run_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 0);   // address NACK
        run_txn(7'h21, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0);   // read 0x3C
        run_txn(7'h33, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1);   // Go while busy is ignored
        run_txn(7'h11, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 0);   // data NACK

        // Reset during data bit 4 of a write
        begin
            int s0;
            s0 = nstart;
            sl_ack_a = 1'b1; sl_ack_d = 1'b1; sl_rw = 1'b0;
            SlaveAddress = 7'h2A; ReadWrite = 1'b0; DataIn = 8'hF0; Go = 1'b1;
            @(posedge clock); #1;
            Go = 1'b0;
            for (int i = 0; i < 3000 && !(nstart != s0 && cap_n >= 13); i++) begin
                @(posedge clock); #1;
            end
            chk("reach_data4", (nstart != s0 && cap_n >= 13) ? 1 : 0, 1);
            Reset = 1'b1;
            #1;
            chk("mid_rst_scl", SCL, 1);
            chk("mid_rst_sdadrive", SDADrive, 0);
            chk("mid_rst_baud", BaudEnable, 0);
            chk("mid_rst_busy", Busy, 0);
            @(posedge clock); #1;
            Reset = 1'b0;
            m_dout = '0;
            repeat (2) @(posedge clock);
            #1;
        end
        run_txn(7'h6B, 1'b1, 8'h00, 1'b1, 1'b1, 8'h96, 0);

        // Back to back: the second Go arrives in the cycle right after Done
        run_txn(7'h0F, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 0);
        run_txn(7'h70, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h00, 0);

        for (int k = 0; k < 10; k++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom % 4) != 0, ($urandom % 4) != 0, 8'($urandom), 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
